// File: rtl/data_write_buffer.sv
// data_write_buffer: posted-write buffer between the data bridge and the AXI
// sram-like data port. Stores are acknowledged once they are buffered and then
// drain in order. A load is only forwarded after every buffered store has
// completed, and only one load is in flight at a time.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   up_req/up_wr/up_size     upstream sram-like request
//   up_addr/up_wdata         upstream address and write data
//   up_rdata                 load data, valid with up_data_ok of a load
//   up_addr_ok/up_data_ok    upstream handshake
//   dn_req/dn_wr/dn_size     downstream sram-like request (registered)
//   dn_addr/dn_wdata         downstream address and write data (registered)
//   dn_rdata                 downstream read data
//   dn_addr_ok/dn_data_ok    downstream handshake
//   buf_empty                no buffered or in-flight store
//   buf_count                occupied entries
module data_write_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             up_req,
    input  logic             up_wr,
    input  logic [1:0]       up_size,
    input  logic [31:0]      up_addr,
    input  logic [31:0]      up_wdata,
    output logic [31:0]      up_rdata,
    output logic             up_addr_ok,
    output logic             up_data_ok,
    output logic             dn_req,
    output logic             dn_wr,
    output logic [1:0]       dn_size,
    output logic [31:0]      dn_addr,
    output logic [31:0]      dn_wdata,
    input  logic [31:0]      dn_rdata,
    input  logic             dn_addr_ok,
    input  logic             dn_data_ok,
    output logic             buf_empty,
    output logic [PTR_W:0]   buf_count
);

    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        DS_IDLE,
        DS_WADDR,
        DS_WDATA,
        DS_RADDR,
        DS_RDATA
    } ds_state_e;

    logic [1:0]       fifo_size_q  [DEPTH];
    logic [31:0]      fifo_addr_q  [DEPTH];
    logic [31:0]      fifo_wdata_q [DEPTH];

    logic [CNT_W-1:0] wptr_q;
    logic [CNT_W-1:0] rptr_q;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] head_idx;
    logic             full;
    logic             wr_acc;
    logic             rd_acc;

    ds_state_e        state_q;
    logic             rd_pend_q;
    logic             wr_ack_q;
    logic [31:0]      rd_addr_q;
    logic [1:0]       rd_size_q;
    logic             dn_req_q;
    logic             dn_wr_q;
    logic [1:0]       dn_size_q;
    logic [31:0]      dn_addr_q;
    logic [31:0]      dn_wdata_q;

    // Occupancy: pointers carry one extra wrap bit, so the difference is exact.
    assign count    = wptr_q - rptr_q;
    assign full     = (count == CNT_W'(DEPTH));
    assign head_idx = rptr_q[PTR_W-1:0];

    // Any pending load stalls all upstream traffic; a load also waits for an
    // idle, empty buffer so it can never overtake a store.
    assign wr_acc = up_req & up_wr & ~full & ~rd_pend_q;
    assign rd_acc = up_req & ~up_wr & (count == '0) & (state_q == DS_IDLE) & ~rd_pend_q;

    assign up_addr_ok = wr_acc | rd_acc;
    // Load completion passes straight through from downstream.
    assign up_data_ok = wr_ack_q | ((state_q == DS_RDATA) & dn_data_ok);
    assign up_rdata   = (state_q == DS_RDATA) ? dn_rdata : '0;

    assign dn_req   = dn_req_q;
    assign dn_wr    = dn_wr_q;
    assign dn_size  = dn_size_q;
    assign dn_addr  = dn_addr_q;
    assign dn_wdata = dn_wdata_q;

    // The head entry stays counted until its downstream completion.
    assign buf_empty = (count == '0) & (state_q != DS_WADDR) & (state_q != DS_WDATA);
    assign buf_count = count;

    // Entry storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            fifo_size_q[wptr_q[PTR_W-1:0]]  <= up_size;
            fifo_addr_q[wptr_q[PTR_W-1:0]]  <= up_addr;
            fifo_wdata_q[wptr_q[PTR_W-1:0]] <= up_wdata;
        end
    end

    // Pointers, ack flag, load tracking and downstream FSM with registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            state_q    <= DS_IDLE;
            rd_pend_q  <= 1'b0;
            wr_ack_q   <= 1'b0;
            rd_addr_q  <= '0;
            rd_size_q  <= '0;
            dn_req_q   <= 1'b0;
            dn_wr_q    <= 1'b0;
            dn_size_q  <= '0;
            dn_addr_q  <= '0;
            dn_wdata_q <= '0;
        end else begin
            wr_ack_q <= wr_acc;
            if (wr_acc) begin
                wptr_q <= wptr_q + CNT_W'(1);
            end
            if (rd_acc) begin
                rd_pend_q <= 1'b1;
                rd_addr_q <= up_addr;
                rd_size_q <= up_size;
            end

            unique case (state_q)
                // Requests being accepted this cycle are launched on the next
                // edge; a store into an empty buffer is its own head entry.
                DS_IDLE: begin
                    if (rd_pend_q || rd_acc) begin
                        state_q   <= DS_RADDR;
                        dn_req_q  <= 1'b1;
                        dn_wr_q   <= 1'b0;
                        dn_addr_q <= rd_acc ? up_addr : rd_addr_q;
                        dn_size_q <= rd_acc ? up_size : rd_size_q;
                    end else if ((count != '0) || wr_acc) begin
                        state_q  <= DS_WADDR;
                        dn_req_q <= 1'b1;
                        dn_wr_q  <= 1'b1;
                        if (count != '0) begin
                            dn_addr_q  <= fifo_addr_q[head_idx];
                            dn_size_q  <= fifo_size_q[head_idx];
                            dn_wdata_q <= fifo_wdata_q[head_idx];
                        end else begin
                            dn_addr_q  <= up_addr;
                            dn_size_q  <= up_size;
                            dn_wdata_q <= up_wdata;
                        end
                    end
                end
                DS_WADDR: begin
                    if (dn_addr_ok) begin
                        state_q  <= DS_WDATA;
                        dn_req_q <= 1'b0;
                    end
                end
                DS_WDATA: begin
                    if (dn_data_ok) begin
                        rptr_q  <= rptr_q + CNT_W'(1);
                        state_q <= DS_IDLE;
                    end
                end
                DS_RADDR: begin
                    if (dn_addr_ok) begin
                        state_q  <= DS_RDATA;
                        dn_req_q <= 1'b0;
                    end
                end
                DS_RDATA: begin
                    if (dn_data_ok) begin
                        rd_pend_q <= 1'b0;
                        state_q   <= DS_IDLE;
                    end
                end
                default: begin
                    state_q  <= DS_IDLE;
                    dn_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/data_write_buffer.md
# data_write_buffer

Posted-write buffer on the data path between the 2-to-1 data bridge and the AXI interface's sram-like data port. Stores are acknowledged upstream as soon as they are buffered and drain to the AXI interface in order. Loads are forwarded only after all buffered stores have completed, which gives strict program ordering with one read in flight. Both sides use the sram-like protocol.

## Interface
Parameters:
- DEPTH, 4 — number of write entries; power of two, at least 2.
- PTR_W, 2 — log2(DEPTH).

Ports:
- clk  in  1  — single clock.
- resetn  in  1  — asynchronous, active-low reset.
- up_req  in  1  — upstream request; held until up_addr_ok.
- up_wr  in  1  — 1 = write, 0 = read.
- up_size  in  2  — 0 = byte, 1 = half, 2 = word.
- up_addr  in  32  — physical address.
- up_wdata  in  32  — write data.
- up_rdata  out  32  — read data; valid with up_data_ok for reads.
- up_addr_ok  out  1  — request accepted this cycle.
- up_data_ok  out  1  — request completed.
- dn_req, dn_wr  out  1 each  — downstream request and direction.
- dn_size  out  2  — downstream transfer size.
- dn_addr, dn_wdata  out  32 each  — downstream address and write data.
- dn_rdata  in  32  — downstream read data.
- dn_addr_ok, dn_data_ok  in  1 each  — downstream handshake.
- buf_empty  out  1  — no buffered or in-flight write.
- buf_count  out  PTR_W+1  — number of occupied entries.

## Operation
- FIFO of DEPTH entries; each entry is {size, addr, wdata}. Read and write pointers are PTR_W+1 bits and wrap modulo 2·DEPTH. count = wptr − rptr. full ⇔ count == DEPTH.
- Write accept: up_addr_ok = up_req & up_wr & !full & !rd_pend, combinational. On accept, push the entry. up_data_ok pulses in the next cycle from a registered flag. No upstream data is returned for writes; up_rdata is don't-care.
- Read accept: up_addr_ok = up_req & !up_wr & (count == 0) & state == DS_IDLE & !rd_pend. On accept, latch addr and size and set rd_pend.
- Downstream FSM:
  - DS_IDLE
    - If rd_pend, go to DS_RADDR.
    - Else if count ≠ 0, go to DS_WADDR.
    - A pending read always outranks writes. A pending read can only exist when the FIFO is empty.
  - DS_WADDR: dn_req = 1, dn_wr = 1, fields from the head entry. On dn_addr_ok, go to DS_WDATA.
  - DS_WDATA: dn_req = 0. On dn_data_ok, pop the head (rptr + 1) and return to DS_IDLE.
  - DS_RADDR: dn_req = 1, dn_wr = 0, latched addr and size. On dn_addr_ok, go to DS_RDATA.
  - DS_RDATA: up_data_ok = dn_data_ok and up_rdata = dn_rdata, both combinational. On dn_data_ok, clear rd_pend and return to DS_IDLE.
- The head entry stays occupied until its dn_data_ok arrives. It counts toward full and buf_empty.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- While rd_pend is set, all upstream requests stall, writes included.
- buf_empty = (count == 0) & state ∉ {DS_WADDR, DS_WDATA}.
- Reset, including mid-operation: pointers = 0, state = DS_IDLE, rd_pend = 0, write-ack flag = 0. Buffered writes are discarded. After a mid-operation reset, a dn_addr_ok or dn_data_ok that arrives while in DS_IDLE is ignored.

## Timing
- Reset values:
  - up_addr_ok, up_data_ok, dn_req, dn_wr = 0.
  - dn_addr, dn_wdata, dn_size, up_rdata = 0.
  - buf_empty = 1, buf_count = 0.
- Write: accept at T, up_data_ok at T+1, dn_req at T+1 at the earliest. With dn_addr_ok at T+1 and dn_data_ok at T+2, the entry frees at the T+2 edge.
- Throughput: one upstream write per cycle until full. Downstream: one write per three cycles at best (DS_WADDR, DS_WDATA, DS_IDLE).
- Read on an empty buffer: accept at T, dn_req at T+1. up_data_ok is in the same cycle as dn_data_ok, with zero added latency.
- dn_* outputs stay stable while dn_req = 1 and no dn_addr_ok has arrived.
- up_data_ok for a write never coincides with a read's up_data_ok, because a read needs count == 0 and a completed read is followed by at least DS_IDLE.

## Test plan
- Single store: sw 0x1234_5678 to 0x1FAF_F000. Required: up_addr_ok at T, up_data_ok at T+1. dn_req carries addr 0x1FAF_F000, size 2, wdata 0x1234_5678. buf_empty rises after dn_data_ok.
- Fill: 5 back-to-back stores with downstream stalled (dn_addr_ok = 0). Required: 4 accepted, buf_count = 4, 5th up_addr_ok = 0. The 5th is accepted in the cycle the first dn_data_ok pops the head.
- Ordering: 3 stores followed by a load to the address of the 2nd store. Required: the load's up_addr_ok is held until buf_count = 0. The downstream sequence is W, W, W, R, and up_rdata equals dn_rdata.
- Read pending blocks writes: a load is in flight and a store arrives. Required: the store gets up_addr_ok only after the load's up_data_ok.
- Simultaneous push and pop at count = 2. Required: count stays 2 and the pointers wrap correctly across 2·DEPTH.
- Reset in DS_WDATA with 3 entries buffered. Required: dn_req = 0, buf_count = 0, buf_empty = 1 immediately. A late dn_data_ok produces no up_data_ok.
